// File: rtl/traffic_lamp_driver.sv
// Registered lamp output stage for a two-direction intersection. It inserts an
// all-red clearance whenever a direction gains right-of-way and latches a fault
// that flashes red on both directions when a request is illegal or conflicting.
module traffic_lamp_driver #(
  parameter int CLEAR_CYCLES = 2,
  parameter int FLASH_HALF   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ns_req,
  input  logic [2:0] ew_req,
  input  logic       fault_clr,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       clearing,
  output logic       fault
);

  localparam int MAX_CNT = (CLEAR_CYCLES > FLASH_HALF) ? CLEAR_CYCLES : FLASH_HALF;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_HALF - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  typedef enum logic [1:0] {
    ST_ALL_RED,
    ST_RUN,
    ST_CLEAR,
    ST_FAULT
  } state_e;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic [2:0]    r_ns_lamp;
  logic [2:0]    r_ew_lamp;
  logic          r_clearing;
  logic          r_fault;

  state_e        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_phase_nxt;
  logic [2:0]    w_ns_lamp_nxt;
  logic [2:0]    w_ew_lamp_nxt;
  logic          w_clearing_nxt;
  logic          w_fault_nxt;

  logic w_ns_valid;
  logic w_ew_valid;
  logic w_legal;
  logic w_entering;

  assign w_ns_valid = (ns_req == LAMP_RED) || (ns_req == LAMP_YELLOW) || (ns_req == LAMP_GREEN);
  assign w_ew_valid = (ew_req == LAMP_RED) || (ew_req == LAMP_YELLOW) || (ew_req == LAMP_GREEN);
  assign w_legal    = w_ns_valid && w_ew_valid && ((ns_req == LAMP_RED) || (ew_req == LAMP_RED));

  // A direction gains right-of-way when its lamp is red and its request is not.
  assign w_entering = ((r_ns_lamp == LAMP_RED) && (ns_req != LAMP_RED)) ||
                      ((r_ew_lamp == LAMP_RED) && (ew_req != LAMP_RED));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_ALL_RED;
      r_cnt      <= '0;
      r_phase    <= 1'b1;
      r_ns_lamp  <= LAMP_RED;
      r_ew_lamp  <= LAMP_RED;
      r_clearing <= 1'b1;
      r_fault    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_ns_lamp  <= w_ns_lamp_nxt;
      r_ew_lamp  <= w_ew_lamp_nxt;
      r_clearing <= w_clearing_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    unique case (r_state)
      ST_ALL_RED, ST_CLEAR: begin
        if (!w_legal) begin
          w_state_nxt = ST_FAULT;
          w_cnt_nxt   = '0;
          w_phase_nxt = 1'b1;
        end else if (r_cnt == CLEAR_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_legal) begin
          w_state_nxt = ST_FAULT;
          w_cnt_nxt   = '0;
          w_phase_nxt = 1'b1;
        end else if (w_entering) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_FAULT: begin
        if (fault_clr && w_legal) begin
          w_state_nxt = ST_ALL_RED;
          w_cnt_nxt   = '0;
          w_phase_nxt = 1'b1;
        end else if (r_cnt == FLASH_LAST) begin
          w_cnt_nxt   = '0;
          w_phase_nxt = ~r_phase;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_ALL_RED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are a function of the upcoming state so they land in registers.
  always_comb begin
    w_ns_lamp_nxt  = LAMP_RED;
    w_ew_lamp_nxt  = LAMP_RED;
    w_clearing_nxt = 1'b0;
    w_fault_nxt    = 1'b0;
    unique case (w_state_nxt)
      ST_ALL_RED, ST_CLEAR: w_clearing_nxt = 1'b1;
      ST_RUN: begin
        w_ns_lamp_nxt = ns_req;
        w_ew_lamp_nxt = ew_req;
      end
      ST_FAULT: begin
        w_fault_nxt = 1'b1;
        if (!w_phase_nxt) begin
          w_ns_lamp_nxt = LAMP_OFF;
          w_ew_lamp_nxt = LAMP_OFF;
        end
      end
      default: w_clearing_nxt = 1'b1;
    endcase
  end

  assign ns_lamp  = r_ns_lamp;
  assign ew_lamp  = r_ew_lamp;
  assign clearing = r_clearing;
  assign fault    = r_fault;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Directed, table-driven bench for traffic_lamp_driver with default parameters
// (2-cycle clearance, 4-cycle flash half-period).
module tb_traffic_lamp_driver;

  logic       clk;
  logic       reset;
  logic [2:0] ns_req;
  logic [2:0] ew_req;
  logic       fault_clr;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       clearing;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0] ns_req;
    logic [2:0] ew_req;
    logic       clr;
    logic [2:0] exp_ns;
    logic [2:0] exp_ew;
    logic       exp_clearing;
    logic       exp_fault;
    string      name;
  } vec_t;

  vec_t vecs[$];

  traffic_lamp_driver #(
    .CLEAR_CYCLES(2),
    .FLASH_HALF  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ns_req   (ns_req),
    .ew_req   (ew_req),
    .fault_clr(fault_clr),
    .ns_lamp  (ns_lamp),
    .ew_lamp  (ew_lamp),
    .clearing (clearing),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [2:0] e_ns, input logic [2:0] e_ew,
                           input logic e_clr, input logic e_flt);
    check({name, ".ns_lamp"}, ns_lamp, e_ns);
    check({name, ".ew_lamp"}, ew_lamp, e_ew);
    check({name, ".clearing"}, {2'b00, clearing}, {2'b00, e_clr});
    check({name, ".fault"}, {2'b00, fault}, {2'b00, e_flt});
  endtask

  task automatic add(input logic [2:0] n, input logic [2:0] e, input logic c,
                     input logic [2:0] en, input logic [2:0] ee, input logic ec,
                     input logic ef, input string nm);
    vec_t v;
    v.ns_req = n; v.ew_req = e; v.clr = c;
    v.exp_ns = en; v.exp_ew = ee; v.exp_clearing = ec; v.exp_fault = ef;
    v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    // Each row: inputs held over one rising edge, expected outputs just after it.
    add(3'b001, 3'b100, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, "allred_1");
    add(3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, "allred_exit");
    add(3'b001, 3'b100, 1'b1, 3'b001, 3'b100, 1'b0, 1'b0, "run_clr_ignored");
    add(3'b010, 3'b100, 1'b0, 3'b010, 3'b100, 1'b0, 1'b0, "ns_yellow");
    add(3'b100, 3'b100, 1'b0, 3'b100, 3'b100, 1'b0, 1'b0, "ns_red");
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, "ew_enter");
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, "ew_clear");
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 1'b0, "ew_green");
    add(3'b100, 3'b010, 1'b0, 3'b100, 3'b010, 1'b0, 1'b0, "ew_yellow");
    add(3'b100, 3'b100, 1'b0, 3'b100, 3'b100, 1'b0, 1'b0, "ew_red");
    add(3'b001, 3'b100, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, "ns_enter");
    add(3'b001, 3'b100, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, "ns_clear");
    add(3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, "ns_green");
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, "ew_enter2");
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, "ew_clear2");
    add(3'b100, 3'b000, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1, "clear_illegal");
    add(3'b100, 3'b000, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1, "flash_on_1");
    add(3'b011, 3'b100, 1'b1, 3'b100, 3'b100, 1'b0, 1'b1, "clr_illegal_ignored");
    add(3'b100, 3'b000, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1, "flash_on_3");
    for (int i = 0; i < 4; i++)
      add(3'b100, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, "flash_off");
    add(3'b100, 3'b000, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1, "flash_on_again");
    add(3'b100, 3'b001, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0, "fault_exit");
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, "post_fault_allred");
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 1'b0, "post_fault_run");
    for (int i = 0; i < 4; i++)
      add(3'b001, 3'b001, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1, "conflict_on");
    for (int i = 0; i < 2; i++)
      add(3'b001, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, "conflict_off");

    reset = 1'b1; ns_req = 3'b001; ew_req = 3'b100; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'b100, 3'b100, 1'b1, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      ns_req = vecs[i].ns_req; ew_req = vecs[i].ew_req; fault_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      check_all(vecs[i].name, vecs[i].exp_ns, vecs[i].exp_ew,
                vecs[i].exp_clearing, vecs[i].exp_fault);
    end

    // Asynchronous reset in the middle of a flash off-phase, well before the next edge.
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 3'b100, 3'b100, 1'b1, 1'b0);
    #2;
    ns_req = 3'b100; ew_req = 3'b100; fault_clr = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_allred_1", 3'b100, 3'b100, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_run", 3'b100, 3'b100, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
